mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the single block-wide memory port among I-cache, D-cache and DMA.
//  Sits directly downstream of both caches: consumes their readM/writeM misses.
//  Forwards each granted request to memory and returns input_readyM/doneM pulses.
//  Drives bus_granted to both caches while DMA owns the bus; one owner at a time.
// PARAMETERS
//  WORD_SIZE   16           address width and cache word width
//  BLOCK_SIZE  4*WORD_SIZE  width of one cache-block transfer
// PORTS
//  clk              in     1      clock
//  reset_n          in     1      synchronous, active-low reset
//  i_readM          in     1      I-cache block read request
//  i_address        in     WORD   I-cache request address
//  i_dataM          inout  BLOCK  driven with read data only while i_input_readyM=1, else z
//  i_input_readyM   out    1      read data valid for I-cache (1-cycle pulse)
//  d_readM/d_writeM in     1      D-cache block read / write request
//  d_address        in     WORD   D-cache request address
//  d_dataM          inout  BLOCK  arbiter drives it on D read completion; D-cache drives it on writes
//  d_input_readyM   out    1      read data valid for D-cache (1-cycle pulse)
//  d_doneM          out    1      write completed for D-cache (1-cycle pulse)
//  dma_request      in     1      DMA asks for the memory bus
//  bus_granted      out    1      DMA owns the bus (broadcast to both caches)
//  mem_readM        out    1      memory read strobe
//  mem_writeM       out    1      memory write strobe
//  mem_address      out    WORD   memory address
//  mem_wdata        out    BLOCK  write data to memory
//  mem_rdata        in     BLOCK  read data from memory
//  mem_input_ready  in     1      memory read data valid
//  mem_done         in     1      memory write finished
//  num_grant_i/d    out    WORD   grants issued to I / D
//  num_conflict     out    WORD   IDLE cycles with both caches requesting
// BEHAVIOUR
//  - States: IDLE, GNT_I, GNT_D, GNT_DMA. State, last_grant and counters are registered.
//  - Reset: state=IDLE, last_grant=I, so D wins the first tie.
//    All outputs 0 at reset, and both client dataM buses are z.
//  - IDLE decision: DMA > caches. dma_request -> GNT_DMA.
//    Else if only one cache requests, grant that cache.
//    Else if both request, grant the one not equal to last_grant and count num_conflict.
//  - A cache request means i_readM, or (d_readM|d_writeM).
//    Entering GNT_x updates last_grant and increments num_grant_x.
//  - GNT_x: mem_* is a combinational copy of the granted client's strobes, address and data.
//    mem_input_ready/mem_done are routed only to the granted client; the other client sees 0.
//  - Completion: mem_input_ready (read) or mem_done (write) is seen -> next state IDLE.
//    Completion needs at least 1 IDLE cycle before the next grant.
//  - Abort: the granted client drops its strobe before completion.
//    mem strobes fall in the same cycle; next state IDLE; no pulse reaches the client.
//  - GNT_DMA: bus_granted=1 (registered); all mem strobes 0.
//    Return to IDLE on the edge after dma_request=0.
//  - DMA arriving mid-transfer waits; it takes IDLE priority after completion.
//  - Latency: request at IDLE edge t -> grant at t+1 -> mem strobe during t+1.
//    The response is passed back to the client combinationally in the same cycle.
//  - Counters wrap modulo 2^WORD_SIZE.
//  - Reset mid-transfer: IDLE next edge, strobes 0, pending memory reply ignored.
// TESTING
//  1 i_readM=1, addr 0x0040, mem_input_ready at cycle 3, rdata 0x1111_2222_3333_4444.
//    -> i_input_readyM pulse in the cycle rdata appears on i_dataM; num_grant_i=1.
//  2 i_readM and d_readM both rise after reset.
//    -> D served first, then I after 1 IDLE cycle; num_conflict=1.
//    A second tie -> I served first.
//  3 d_writeM=1, addr 0x0104.
//    -> mem_wdata equals d_dataM; d_doneM pulses with mem_done; d_input_readyM stays 0.
//  4 dma_request=1 during a D read.
//    -> bus_granted=0 until the read completes, then 1 on the edge after IDLE.
//    dma_request=0 -> bus_granted=0 next edge.
//  5 D grant, then d_readM drops before mem_input_ready.
//    -> mem_readM=0 the same cycle; no d_input_readyM; IDLE next edge.
//  6 reset_n=0 mid-I-read.
//    -> IDLE, counters 0, i_dataM z, and a late mem_input_ready is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single block-wide memory port between I-cache, D-cache and DMA.
// One owner at a time; DMA wins in IDLE, and the caches alternate when both request.
module mem_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int BLOCK_SIZE = 4 * WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_readM,
  input  logic [WORD_SIZE-1:0]  i_address,
  inout  wire  [BLOCK_SIZE-1:0] i_dataM,
  output logic                  i_input_readyM,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  input  logic [WORD_SIZE-1:0]  d_address,
  inout  wire  [BLOCK_SIZE-1:0] d_dataM,
  output logic                  d_input_readyM,
  output logic                  d_doneM,
  input  logic                  dma_request,
  output logic                  bus_granted,
  output logic                  mem_readM,
  output logic                  mem_writeM,
  output logic [WORD_SIZE-1:0]  mem_address,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  input  logic                  mem_input_ready,
  input  logic                  mem_done,
  output logic [WORD_SIZE-1:0]  num_grant_i,
  output logic [WORD_SIZE-1:0]  num_grant_d,
  output logic [WORD_SIZE-1:0]  num_conflict
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, GNT_DMA} state_t;
  typedef enum logic {LAST_I, LAST_D} owner_t;

  state_t state;
  owner_t last_grant;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req = i_readM;
  assign d_req = d_readM | d_writeM;

  // On a tie the cache that was not granted most recently goes first.
  assign pick_d = d_req && (!i_req || (last_grant == LAST_I));

  always_comb begin
    mem_readM   = 1'b0;
    mem_writeM  = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (state)
      GNT_I: begin
        mem_readM   = i_readM;
        mem_address = i_address;
      end
      GNT_D: begin
        mem_readM   = d_readM;
        mem_writeM  = d_writeM;
        mem_address = d_address;
        mem_wdata   = d_dataM;
      end
      default: begin
      end
    endcase
  end

  // Replies are gated by the live strobe so an aborted request never sees a pulse.
  assign i_input_readyM = (state == GNT_I) && i_readM && mem_input_ready;
  assign d_input_readyM = (state == GNT_D) && d_readM && mem_input_ready;
  assign d_doneM        = (state == GNT_D) && d_writeM && mem_done;

  assign i_dataM = i_input_readyM ? mem_rdata : {BLOCK_SIZE{1'bz}};
  assign d_dataM = d_input_readyM ? mem_rdata : {BLOCK_SIZE{1'bz}};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= LAST_I;
      bus_granted  <= 1'b0;
      num_grant_i  <= '0;
      num_grant_d  <= '0;
      num_conflict <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_request) begin
            state       <= GNT_DMA;
            bus_granted <= 1'b1;
          end else if (i_req || d_req) begin
            if (i_req && d_req)
              num_conflict <= num_conflict + WORD_SIZE'(1);
            if (pick_d) begin
              state       <= GNT_D;
              last_grant  <= LAST_D;
              num_grant_d <= num_grant_d + WORD_SIZE'(1);
            end else begin
              state       <= GNT_I;
              last_grant  <= LAST_I;
              num_grant_i <= num_grant_i + WORD_SIZE'(1);
            end
          end
        end
        GNT_I: begin
          if (!i_readM || i_input_readyM)
            state <= IDLE;
        end
        GNT_D: begin
          if (!d_req || d_input_readyM || d_doneM)
            state <= IDLE;
        end
        GNT_DMA: begin
          if (!dma_request) begin
            state       <= IDLE;
            bus_granted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model of who should own the memory port and the grant counters.
module tb_mem_arbiter;
  localparam int W = 16;
  localparam int B = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_readM;
  logic [W-1:0] i_address;
  wire  [B-1:0] i_dataM;
  logic         i_input_readyM;
  logic         d_readM;
  logic         d_writeM;
  logic [W-1:0] d_address;
  wire  [B-1:0] d_dataM;
  logic         d_input_readyM;
  logic         d_doneM;
  logic         dma_request;
  logic         bus_granted;
  logic         mem_readM;
  logic         mem_writeM;
  logic [W-1:0] mem_address;
  logic [B-1:0] mem_wdata;
  logic [B-1:0] mem_rdata;
  logic         mem_input_ready;
  logic         mem_done;
  logic [W-1:0] num_grant_i;
  logic [W-1:0] num_grant_d;
  logic [W-1:0] num_conflict;

  logic         d_drive;
  logic [B-1:0] d_wdata;

  assign d_dataM = d_drive ? d_wdata : {B{1'bz}};

  int checks = 0;
  int errors = 0;

  // Reference model: which cache was granted last, and expected counter values.
  bit           last_d;
  logic [W-1:0] exp_gi;
  logic [W-1:0] exp_gd;
  logic [W-1:0] exp_conf;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(W), .BLOCK_SIZE(B)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_address(i_address), .i_dataM(i_dataM), .i_input_readyM(i_input_readyM),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_dataM(d_dataM),
    .d_input_readyM(d_input_readyM), .d_doneM(d_doneM),
    .dma_request(dma_request), .bus_granted(bus_granted),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_input_ready(mem_input_ready), .mem_done(mem_done),
    .num_grant_i(num_grant_i), .num_grant_d(num_grant_d), .num_conflict(num_conflict)
  );

  task automatic check_output(input string tag, input logic [B-1:0] observed, input logic [B-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit ri, input bit dr, input bit dw, input bit dma,
                                input logic [W-1:0] ia, input logic [W-1:0] da, input logic [B-1:0] wd);
    i_readM     = ri;
    d_readM     = dr;
    d_writeM    = dw;
    dma_request = dma;
    i_address   = ia;
    d_address   = da;
    d_wdata     = wd;
    d_drive     = dw;
  endtask

  task automatic note_grant(input bit is_d);
    if (is_d) exp_gd++;
    else exp_gi++;
    last_d = is_d;
  endtask

  task automatic check_counters;
    check_output("num_grant_i", B'(num_grant_i), B'(exp_gi));
    check_output("num_grant_d", B'(num_grant_d), B'(exp_gd));
    check_output("num_conflict", B'(num_conflict), B'(exp_conf));
  endtask

  // Called in the first cycle of a cache grant; ends in the following IDLE cycle.
  task automatic serve(input bit is_d, input bit is_wr, input bit abort, input int lat,
                       input logic [B-1:0] rdata);
    logic [W-1:0] addr;
    addr = is_d ? d_address : i_address;
    check_output("grant_read", B'(mem_readM), B'(!is_wr));
    check_output("grant_write", B'(mem_writeM), B'(is_wr));
    check_output("grant_addr", B'(mem_address), B'(addr));
    if (is_wr) check_output("grant_wdata", mem_wdata, d_wdata);
    check_output("no_bus_grant", B'(bus_granted), B'(0));
    for (int c = 0; c < lat; c++) begin
      tick;
      check_output("strobe_held", B'(mem_readM | mem_writeM), B'(1));
    end
    mem_rdata = rdata;
    if (abort) begin
      if (is_d) begin d_readM = 1'b0; d_writeM = 1'b0; d_drive = 1'b0; end
      else i_readM = 1'b0;
      mem_input_ready = 1'b1;
      mem_done        = 1'b1;
      #1;
      check_output("abort_strobes", B'({mem_readM, mem_writeM}), B'(0));
      check_output("abort_pulses", B'({i_input_readyM, d_input_readyM, d_doneM}), B'(0));
    end else begin
      if (is_wr) mem_done = 1'b1;
      else mem_input_ready = 1'b1;
      #1;
      check_output("reply_pulses", B'({i_input_readyM, d_input_readyM, d_doneM}),
                   B'({!is_d, is_d && !is_wr, is_wr}));
      if (!is_wr) check_output("reply_data", is_d ? d_dataM : i_dataM, rdata);
    end
    tick;
    mem_input_ready = 1'b0;
    mem_done        = 1'b0;
    if (is_d) begin d_readM = 1'b0; d_writeM = 1'b0; d_drive = 1'b0; end
    else i_readM = 1'b0;
    #1;
    check_output("idle_strobes", B'({mem_readM, mem_writeM}), B'(0));
    check_output("idle_addr", B'(mem_address), B'(0));
  endtask

  // One arbitration round starting in an IDLE cycle: optional DMA tenure, then every requester served.
  task automatic run_round(input bit ri, input bit rd, input bit rw, input bit dma,
                           input bit ab1, input bit ab2, input int lat1, input int lat2);
    bit both;
    bit first_d;
    both = ri && rd;
    apply_stimulus(ri, rd && !rw, rd && rw, dma, W'($urandom), W'($urandom), {$urandom, $urandom});
    tick;
    if (dma) begin
      check_output("dma_grant", B'(bus_granted), B'(1));
      check_output("dma_strobes", B'({mem_readM, mem_writeM}), B'(0));
      repeat ($urandom_range(0, 2)) tick;
      check_output("dma_hold", B'(bus_granted), B'(1));
      dma_request = 1'b0;
      tick;
      check_output("dma_release", B'(bus_granted), B'(0));
      tick;
    end
    first_d = both ? !last_d : rd;
    if (both) exp_conf++;
    note_grant(first_d);
    serve(first_d, first_d && rw, ab1, lat1, {$urandom, $urandom});
    if (both) begin
      tick;
      note_grant(!first_d);
      serve(!first_d, !first_d && rw, ab2, lat2, {$urandom, $urandom});
    end
    check_counters();
  endtask

  initial begin
    reset_n         = 1'b0;
    mem_rdata       = '0;
    mem_input_ready = 1'b0;
    mem_done        = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    last_d   = 1'b0;
    exp_gi   = '0;
    exp_gd   = '0;
    exp_conf = '0;
    tick;
    tick;
    reset_n = 1'b1;
    #1;
    check_output("rst_strobes", B'({mem_readM, mem_writeM, bus_granted}), B'(0));
    check_output("rst_pulses", B'({i_input_readyM, d_input_readyM, d_doneM}), B'(0));
    check_output("rst_addr", B'(mem_address), B'(0));
    check_output("rst_wdata", mem_wdata, 64'd0);
    check_counters();

    // I-cache block read answered in the third grant cycle.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, '0, '0);
    tick;
    note_grant(1'b0);
    serve(1'b0, 1'b0, 1'b0, 2, 64'h1111_2222_3333_4444);
    check_counters();

    // Tie after reset goes to D; D re-requesting while I waits is a second tie won by I.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0090, '0);
    tick;
    exp_conf++;
    note_grant(1'b1);
    check_output("t2_conflict", B'(num_conflict), B'(1));
    serve(1'b1, 1'b0, 1'b0, 1, 64'hAAAA_0000_BBBB_0001);
    d_readM = 1'b1;
    tick;
    exp_conf++;
    note_grant(1'b0);
    serve(1'b0, 1'b0, 1'b0, 0, 64'h0123_4567_89AB_CDEF);
    tick;
    note_grant(1'b1);
    serve(1'b1, 1'b0, 1'b0, 0, 64'hFEDC_BA98_7654_3210);
    check_counters();

    // D-cache block write.
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0104, 64'hDEAD_BEEF_0BAD_F00D);
    tick;
    note_grant(1'b1);
    serve(1'b1, 1'b1, 1'b0, 1, 64'h5555_5555_5555_5555);
    check_counters();

    // DMA arriving during a D read waits for completion and one IDLE cycle.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0200, '0);
    tick;
    note_grant(1'b1);
    dma_request = 1'b1;
    serve(1'b1, 1'b0, 1'b0, 1, 64'h0F0F_0F0F_F0F0_F0F0);
    check_output("t4_dma_wait", B'(bus_granted), B'(0));
    tick;
    check_output("t4_dma_grant", B'(bus_granted), B'(1));
    dma_request = 1'b0;
    tick;
    check_output("t4_dma_drop", B'(bus_granted), B'(0));

    // D read aborted before the memory answers.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h0300, '0);
    tick;
    note_grant(1'b1);
    serve(1'b1, 1'b0, 1'b1, 1, 64'h7777_8888_9999_AAAA);
    check_counters();

    // Reset in the middle of an I read; the late memory reply must be ignored.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0400, '0, '0);
    tick;
    check_output("t6_granted", B'(mem_readM), B'(1));
    reset_n = 1'b0;
    tick;
    reset_n   = 1'b1;
    i_readM   = 1'b0;
    last_d    = 1'b0;
    exp_gi    = '0;
    exp_gd    = '0;
    exp_conf  = '0;
    mem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
    mem_input_ready = 1'b1;
    #1;
    check_output("t6_no_pulse", B'(i_input_readyM), B'(0));
    check_output("t6_strobes", B'({mem_readM, mem_writeM}), B'(0));
    check_counters();
    tick;
    mem_input_ready = 1'b0;
    check_output("t6_still_idle", B'(mem_readM), B'(0));

    // Randomized rounds checked against the model.
    for (int r = 0; r < 60; r++) begin
      bit ri;
      bit rd;
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) rd = 1'b1;
      run_round(ri, rd, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
